// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with one full-adder cell, LSB first,
// start/busy/done handshake and a registered result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, s, c, last;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    s       = a_q[0] ^ b_q[0] ^ c_q;
    c       = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    // start is honoured from IDLE and DONE alike, which gives back-to-back issue
    if (state_q != RUN && start_i) begin
      state_d = RUN;
      a_d     = a_i;
      b_d     = b_i;
      w_d     = '0;
      c_d     = cin_i;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d   = {1'b0, a_q[WIDTH-1:1]};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
      w_d   = {s, w_q[WIDTH-1:1]};
      c_d   = c;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        sum_d   = {s, w_q[WIDTH-1:1]};
        cout_d  = c;
      end
    end else begin
      state_d = IDLE;
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH 2, 8 and 32.
module tb_serial_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic        st2 = 0, ci2 = 0, by2, dn2, co2;
  logic [1:0]  a2 = 0, b2 = 0, s2;
  logic        st8 = 0, ci8 = 0, by8, dn8, co8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        st32 = 0, ci32 = 0, by32, dn32, co32;
  logic [31:0] a32 = 0, b32 = 0, s32;

  serial_adder #(.WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .start_i(st2), .a_i(a2), .b_i(b2),
    .cin_i(ci2), .busy_o(by2), .done_o(dn2), .sum_o(s2), .cout_o(co2));
  serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start_i(st8), .a_i(a8), .b_i(b8),
    .cin_i(ci8), .busy_o(by8), .done_o(dn8), .sum_o(s8), .cout_o(co8));
  serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .start_i(st32), .a_i(a32), .b_i(b32),
    .cin_i(ci32), .busy_o(by32), .done_o(dn32), .sum_o(s32), .cout_o(co32));

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] rd(input int w, input int k);
    case (w)
      2:  return k == 0 ? 33'(by2)  : k == 1 ? 33'(dn2)  : k == 2 ? 33'(s2)  : 33'(co2);
      8:  return k == 0 ? 33'(by8)  : k == 1 ? 33'(dn8)  : k == 2 ? 33'(s8)  : 33'(co8);
      default: return k == 0 ? 33'(by32) : k == 1 ? 33'(dn32) : k == 2 ? 33'(s32) : 33'(co32);
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b, input logic ci);
    case (w)
      2:  begin st2 = st;  a2 = a[1:0]; b2 = b[1:0]; ci2 = ci; end
      8:  begin st8 = st;  a8 = a[7:0]; b8 = b[7:0]; ci8 = ci; end
      default: begin st32 = st; a32 = a; b32 = b; ci32 = ci; end
    endcase
  endtask

  // Pulse start for one edge; returns 1 time unit after that edge (E0).
  task automatic go(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci);
    drive(w, 1'b1, a, b, ci);
    @(posedge clk); #1;
    drive(w, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
  endtask

  // Walks the WIDTH cycles after E0, checking busy/done/held sum, then the result after E(WIDTH).
  task automatic run(input string tag, input int w, input logic [31:0] prev, input logic [31:0] es,
                     input logic ec, input int ign);
    for (int n = 1; n <= w; n++) begin
      chk({tag, ".busy"}, rd(w, 0), 33'd1);
      chk({tag, ".nodone"}, rd(w, 1), 33'd0);
      chk({tag, ".hold"}, rd(w, 2), 33'(prev));
      if (n == ign) drive(w, 1'b1, 32'hFF, 32'hFF, 1'b1);
      @(posedge clk); #1;
      if (n == ign) drive(w, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    chk({tag, ".done"}, rd(w, 1), 33'd1);
    chk({tag, ".busy0"}, rd(w, 0), 33'd0);
    chk({tag, ".sum"}, rd(w, 2), 33'(es));
    chk({tag, ".cout"}, rd(w, 3), 33'(ec));
  endtask

  task automatic idle(input string tag, input int w);
    @(posedge clk); #1;
    chk({tag, ".idle_done"}, rd(w, 1), 33'd0);
    chk({tag, ".idle_busy"}, rd(w, 0), 33'd0);
  endtask

  initial begin
    logic [2:0] t;
    logic [1:0] pa, pb;
    logic [31:0] prev;
    #2;
    chk("rst.busy8", rd(8, 0), 33'd0);
    chk("rst.done8", rd(8, 1), 33'd0);
    chk("rst.sum8", rd(8, 2), 33'd0);
    chk("rst.cout8", rd(8, 3), 33'd0);
    chk("rst.sum32", rd(32, 2), 33'd0);
    @(negedge clk); rst_n = 1'b1;
    // WIDTH=2 exhaustive sweep, each new op started in the previous DONE cycle
    prev = 0;
    for (int i = 0; i < 32; i++) begin
      pa = 2'(i >> 3);
      pb = 2'(i >> 1);
      t = 3'(pa) + 3'(pb) + 3'(i & 1);
      go(2, 32'(pa), 32'(pb), i[0]);
      run($sformatf("w2.%0d", i), 2, prev, 32'(t[1:0]), t[2], 0);
      prev = 32'(t[1:0]);
    end
    idle("w2", 2);
    // WIDTH=8 directed
    go(8, 32'hFF, 32'h01, 1'b0);
    run("ff+01", 8, 32'h00, 32'h00, 1'b1, 0);
    idle("ff+01", 8);
    go(8, 32'hA5, 32'h5A, 1'b1);
    run("a5+5a+1", 8, 32'h00, 32'h00, 1'b1, 0);
    go(8, 32'h12, 32'h34, 1'b0);
    run("b2b.12+34", 8, 32'h00, 32'h46, 1'b0, 0);
    idle("b2b", 8);
    go(8, 32'h0F, 32'h01, 1'b0);
    run("ign.0f+01", 8, 32'h46, 32'h10, 1'b0, 3);
    idle("ign", 8);
    // reset during RUN abandons the op
    go(8, 32'h33, 32'h44, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.busy", rd(8, 0), 33'd0);
    chk("mrst.sum", rd(8, 2), 33'd0);
    chk("mrst.cout", rd(8, 3), 33'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("mrst.nodone", rd(8, 1), 33'd0);
    end
    go(8, 32'h80, 32'h80, 1'b0);
    run("80+80", 8, 32'h00, 32'h00, 1'b1, 0);
    idle("80+80", 8);
    // WIDTH=32 full counter range and wrap
    go(32, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run("w32.max", 32, 32'h0, 32'h0, 1'b1, 0);
    idle("w32.max", 32);
    go(32, 32'h1234_5678, 32'h1111_1111, 1'b0);
    run("w32.next", 32, 32'h0, 32'h2345_6789, 1'b0, 0);
    idle("w32.next", 32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
